// File: rtl/cmp_search_ctrl.sv
// Binary-search master for an external combinational magnitude comparator.
// It drives the comparator's "a" operand and narrows [lo, hi] until the comparator reports a match.
module cmp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_higher,
    input  logic             cmp_lower,
    input  logic             cmp_same,
    output logic [0:WIDTH-1] guess,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [0:WIDTH-1] result,
    output logic [7:0]       steps
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [0:WIDTH-1] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [0:WIDTH-1] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [0:WIDTH-1] MAX_VAL  = {WIDTH{1'b1}};

    // Midpoint with a spare bit so the span can never overflow.
    function automatic logic [0:WIDTH-1] mid(input logic [0:WIDTH-1] l, input logic [0:WIDTH-1] h);
        logic [WIDTH:0] span_v;
        logic [WIDTH:0] sum_v;
        span_v = {1'b0, h} - {1'b0, l};
        sum_v  = {1'b0, l} + (span_v >> 1);
        return sum_v[WIDTH-1:0];
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [0:WIDTH-1] guess_r;
    logic [0:WIDTH-1] guess_s;
    logic [0:WIDTH-1] lo_r;
    logic [0:WIDTH-1] lo_s;
    logic [0:WIDTH-1] hi_r;
    logic [0:WIDTH-1] hi_s;
    logic [0:WIDTH-1] result_r;
    logic [0:WIDTH-1] result_s;
    logic [7:0]       steps_r;
    logic [7:0]       steps_s;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [2:0]       flags_s;

    assign flags_s = {cmp_same, cmp_higher, cmp_lower};

    // Next-state and datapath update for one probe per cycle.
    always_comb begin
        state_s  = state_r;
        guess_s  = guess_r;
        lo_s     = lo_r;
        hi_s     = hi_r;
        result_s = result_r;
        steps_s  = steps_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_s = ST_PROBE;
                    lo_s    = ZERO_VAL;
                    hi_s    = MAX_VAL;
                    guess_s = mid(ZERO_VAL, MAX_VAL);
                    steps_s = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PROBE: begin
                steps_s = steps_r + 8'd1;
                case (flags_s)
                    3'b100: begin
                        result_s = guess_r;
                        state_s  = ST_DONE;
                    end
                    3'b010: begin
                        // guess==lo means the target would lie below the window: inconsistent.
                        if (guess_r == lo_r) begin
                            state_s = ST_ERR;
                        end else begin
                            hi_s    = guess_r - ONE_VAL;
                            guess_s = mid(lo_r, guess_r - ONE_VAL);
                        end
                    end
                    3'b001: begin
                        if (guess_r == hi_r) begin
                            state_s = ST_ERR;
                        end else begin
                            lo_s    = guess_r + ONE_VAL;
                            guess_s = mid(guess_r + ONE_VAL, hi_r);
                        end
                    end
                    default: begin
                        state_s = ST_ERR;
                    end
                endcase
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status flags are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            guess_r  <= ZERO_VAL;
            lo_r     <= ZERO_VAL;
            hi_r     <= MAX_VAL;
            result_r <= ZERO_VAL;
            steps_r  <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            guess_r  <= guess_s;
            lo_r     <= lo_s;
            hi_r     <= hi_s;
            result_r <= result_s;
            steps_r  <= steps_s;
            busy_r   <= (state_s == ST_PROBE);
            done_r   <= (state_s == ST_DONE);
            err_r    <= (state_s == ST_ERR);
        end
    end

    assign guess  = guess_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign result = result_r;
    assign steps  = steps_r;

    cmp_search_ctrl_chk #(.WIDTH(WIDTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_probe (state_r == ST_PROBE),
        .busy     (busy_r),
        .done     (done_r),
        .err      (err_r),
        .lo       (lo_r),
        .hi       (hi_r),
        .guess    (guess_r),
        .steps    (steps_r)
    );

endmodule

// Invariant checker: window ordering, guess containment, probe bound, exclusive status.
module cmp_search_ctrl_chk #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             in_probe,
    input logic             busy,
    input logic             done,
    input logic             err,
    input logic [0:WIDTH-1] lo,
    input logic [0:WIDTH-1] hi,
    input logic [0:WIDTH-1] guess,
    input logic [7:0]       steps
);

    localparam logic [7:0] MAX_STEPS = 8'(WIDTH + 1);

    // Sample invariants on every active edge outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0({busy, done, err}));
            assert (steps <= MAX_STEPS);
            if (in_probe) begin
                assert (lo <= hi);
                assert ((guess >= lo) && (guess <= hi));
            end
        end
    end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Scoreboard bench: a stimulus thread queues expected outcomes from a reference search model,
// and per-DUT monitors compare each completed search (probe sequence, result, steps, status).
module tb_cmp_search_ctrl;

    typedef struct {
        int result;
        int steps;
        int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start2;
    logic [0:3] target4, guess4, result4;
    logic [0:1] target2, guess2, result2;
    logic       busy4, done4, err4, busy2, done2, err2;
    logic [7:0] steps4, steps2;
    logic       h4, l4, s4, h2, l2, s2;
    int         mode4;

    int   nchecks = 0;
    int   nerrors = 0;
    int   last_res4 = 0;
    int   last_res2 = 0;
    exp_t exp_q4[$];
    exp_t exp_q2[$];
    int   exp_g4[$];
    int   exp_g2[$];
    int   obs4[$];
    int   obs2[$];
    bit   pbusy4 = 1'b0;
    bit   pbusy2 = 1'b0;

    always #5 clk = ~clk;

    // Comparator models: mode 1 returns no flag, mode 2 always claims "higher".
    always_comb begin
        case (mode4)
            1:       {h4, l4, s4} = 3'b000;
            2:       {h4, l4, s4} = 3'b100;
            default: {h4, l4, s4} = {guess4 > target4, guess4 < target4, guess4 == target4};
        endcase
    end
    assign {h2, l2, s2} = {guess2 > target2, guess2 < target2, guess2 == target2};

    cmp_search_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .cmp_higher(h4), .cmp_lower(l4), .cmp_same(s4),
        .guess(guess4), .busy(busy4), .done(done4), .err(err4),
        .result(result4), .steps(steps4)
    );

    cmp_search_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .cmp_higher(h2), .cmp_lower(l2), .cmp_same(s2),
        .guess(guess2), .busy(busy2), .done(done2), .err(err2),
        .result(result2), .steps(steps2)
    );

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference search over the integer window [lo, hi] of a 2^w value space.
    task automatic push_expect(input int id, input int w, input int t, input int mode);
        int   lo;
        int   hi;
        int   g;
        int   n;
        bit   fin;
        bit   sm;
        bit   hg;
        bit   lw;
        exp_t e;
        lo = 0;
        hi = (1 << w) - 1;
        g = lo + (hi - lo) / 2;
        n = 0;
        fin = 1'b0;
        e.err = 0;
        e.result = (id == 4) ? last_res4 : last_res2;
        while (!fin && n < 40) begin
            if (id == 4) exp_g4.push_back(g);
            else exp_g2.push_back(g);
            n++;
            sm = (mode == 0) && (g == t);
            hg = (mode == 2) || ((mode == 0) && (g > t));
            lw = (mode == 0) && (g < t);
            if (sm && !hg && !lw) begin
                e.result = g;
                fin = 1'b1;
            end else if (hg && !sm && !lw) begin
                if (g == lo) begin e.err = 1; fin = 1'b1; end
                else hi = g - 1;
            end else if (lw && !sm && !hg) begin
                if (g == hi) begin e.err = 1; fin = 1'b1; end
                else lo = g + 1;
            end else begin
                e.err = 1;
                fin = 1'b1;
            end
            if (!fin) g = lo + (hi - lo) / 2;
        end
        e.steps = n;
        if (id == 4) begin exp_q4.push_back(e); last_res4 = e.result; end
        else begin exp_q2.push_back(e); last_res2 = e.result; end
    endtask

    task automatic complete(input int id, input int d, input int e, input int r, input int s);
        exp_t ex;
        int   o[$];
        int   g;
        if (id == 4) o = obs4;
        else o = obs2;
        if ((id == 4 && exp_q4.size() == 0) || (id == 2 && exp_q2.size() == 0)) begin
            check($sformatf("w%0d_unexpected_completion", id), 1, 0);
            return;
        end
        if (id == 4) ex = exp_q4.pop_front();
        else ex = exp_q2.pop_front();
        check($sformatf("w%0d_err", id), e, ex.err);
        check($sformatf("w%0d_done", id), d, 1 - ex.err);
        check($sformatf("w%0d_result", id), r, ex.result);
        check($sformatf("w%0d_steps", id), s, ex.steps);
        check($sformatf("w%0d_probe_count", id), o.size(), ex.steps);
        for (int i = 0; i < ex.steps; i++) begin
            if (id == 4) g = exp_g4.pop_front();
            else g = exp_g2.pop_front();
            if (i < o.size()) check($sformatf("w%0d_guess%0d", id, i), o[i], g);
        end
    endtask

    // Monitor for the 4-bit instance: collect probes, score on leaving PROBE.
    always @(negedge clk) begin
        if (busy4 === 1'b1) begin
            obs4.push_back(int'(guess4));
        end else if (pbusy4) begin
            if (done4 || err4) complete(4, int'(done4), int'(err4), int'(result4), int'(steps4));
            obs4.delete();
        end
        pbusy4 = (busy4 === 1'b1);
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        if (busy2 === 1'b1) begin
            obs2.push_back(int'(guess2));
        end else if (pbusy2) begin
            if (done2 || err2) complete(2, int'(done2), int'(err2), int'(result2), int'(steps2));
            obs2.delete();
        end
        pbusy2 = (busy2 === 1'b1);
    end

    // Issue one search; called and returns at a falling edge with the DUT idle.
    task automatic run(input int id, input int t, input int mode, input int hold);
        int cnt;
        if (id == 4) begin
            target4 = 4'(t);
            mode4 = mode;
            push_expect(4, 4, t, mode);
            start4 = 1'b1;
        end else begin
            target2 = 2'(t);
            push_expect(2, 2, t, 0);
            start2 = 1'b1;
        end
        repeat (hold) @(negedge clk);
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
        cnt = 0;
        while (((id == 4) ? busy4 : busy2) && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("w%0d_search_terminates", id), int'((id == 4) ? busy4 : busy2), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int r;
        int md;
        rst = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        target4 = 4'd0;
        target2 = 2'd0;
        mode4 = 0;
        repeat (2) @(negedge clk);
        check("reset_guess", int'(guess4), 0);
        check("reset_busy", int'(busy4), 0);
        check("reset_done", int'(done4), 0);
        check("reset_err", int'(err4), 0);
        check("reset_result", int'(result4), 0);
        check("reset_steps", int'(steps4), 0);
        check("reset_w2_guess", int'(guess2), 0);
        check("reset_w2_flags", int'({busy2, done2, err2}), 0);
        rst = 1'b0;
        @(negedge clk);

        run(4, 11, 0, 0);
        check("t1_result", int'(result4), 11);
        check("t1_steps", int'(steps4), 2);
        run(4, 0, 0, 0);
        check("t2_result", int'(result4), 0);
        check("t2_steps", int'(steps4), 4);
        run(4, 15, 0, 0);
        check("t3_result", int'(result4), 15);
        check("t3_steps", int'(steps4), 5);
        run(4, 9, 1, 0);
        check("t4_err", int'(err4), 1);
        check("t4_steps", int'(steps4), 1);
        check("t4_busy", int'(busy4), 0);
        check("t4_done", int'(done4), 0);
        run(4, 9, 2, 0);
        check("t5_err", int'(err4), 1);
        check("t5_steps", int'(steps4), 4);
        check("t5_guess", int'(guess4), 0);

        // Reset in the middle of a search.
        target4 = 4'd9;
        mode4 = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("t6_first_guess", int'(guess4), 7);
        check("t6_busy_before_rst", int'(busy4), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_res4 = 0;
        last_res2 = 0;
        check("t6_rst_guess", int'(guess4), 0);
        check("t6_rst_flags", int'({busy4, done4, err4}), 0);
        check("t6_rst_result", int'(result4), 0);
        check("t6_rst_steps", int'(steps4), 0);
        run(4, 5, 0, 1);
        check("t6_hold_result", int'(result4), 5);
        check("t6_hold_steps", int'(steps4), 3);
        run(4, 3, 0, 0);
        run(4, 5, 0, 0);
        check("t6_research_result", int'(result4), 5);
        repeat (3) @(negedge clk);
        check("done_held", int'(done4), 1);
        check("result_held", int'(result4), 5);
        check("busy_idle", int'(busy4), 0);

        for (int t = 0; t < 16; t++) begin
            run(4, t, 0, 0);
            check("w4_sweep_steps_bound", int'(steps4 <= 8'd5), 1);
        end
        for (int t = 0; t < 4; t++) begin
            run(2, t, 0, 0);
            check("w2_sweep_steps_bound", int'(steps2 <= 8'd3), 1);
        end

        repeat (40) begin
            id = ($urandom_range(0, 1) == 0) ? 4 : 2;
            r = int'($urandom_range(0, 7));
            md = (r == 6) ? 1 : ((r == 7) ? 2 : 0);
            if (id == 4) run(4, int'($urandom_range(0, 15)), md, int'($urandom_range(0, 1)));
            else run(2, int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("w4_queue_drained", exp_q4.size(), 0);
        check("w2_queue_drained", exp_q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
